// File: rtl/external_tx_gearbox_fifo.sv
// external_tx_gearbox_fifo: GTX 64b/66b external-gearbox feeder with block FIFO, pause insertion and idle fill
//  i_usrclk2     TXUSRCLK2
//  i_rst_n       asynchronous active-low reset
//  i_startseq    start pulse, sticky until reset
//  i_valid       upstream block valid
//  o_ready       FIFO accepts a block this cycle
//  i_header      sync header of input block
//  i_data        input block payload, [31:0] sent first
//  o_txsequence  GTX TXSEQUENCE
//  o_header      GTX TXHEADER, {1'b0, hdr}
//  o_data        GTX TXDATA
//  o_underflow   one-cycle pulse when an idle block is substituted
//  o_fifo_level  FIFO occupancy
module external_tx_gearbox_fifo #(
    parameter int          DATA_W     = 32,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [1:0]  IDLE_HDR   = 2'b10,
    parameter logic [63:0] IDLE_DATA  = 64'h1E
) (
    input  logic                          i_usrclk2,
    input  logic                          i_rst_n,
    input  logic                          i_startseq,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [1:0]                    i_header,
    input  logic [63:0]                   i_data,
    output logic [6:0]                    o_txsequence,
    output logic [2:0]                    o_header,
    output logic [DATA_W-1:0]             o_data,
    output logic                          o_underflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);
    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [6:0] CNT_MAX = (DATA_W == 32) ? 7'd65 : 7'd32;
    localparam logic [AW:0] FULL   = (AW+1)'(FIFO_DEPTH);

    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
        $error("external_tx_gearbox_fifo: DATA_W must be 32 or 64");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("external_tx_gearbox_fifo: FIFO_DEPTH must be a power of 2, >= 2");
    end

    logic              started_q, started_d;
    logic [6:0]        cnt_q, cnt_d;
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]       level_q, level_d;
    logic [65:0]       mem_q [FIFO_DEPTH];
    logic [65:0]       mem_d [FIFO_DEPTH];
    logic [65:0]       blk_q, blk_d;
    logic [6:0]        seq_q, seq_d;
    logic [2:0]        hdr_q, hdr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              uf_q, uf_d;
    logic              pause, load, upper, empty, push, pop;

    assign o_ready      = started_q && (level_q != FULL);
    assign o_txsequence = seq_q;
    assign o_header     = hdr_q;
    assign o_data       = data_q;
    assign o_underflow  = uf_q;
    assign o_fifo_level = level_q;

    always_comb begin
        started_d = started_q | i_startseq;
        // The start edge itself enters slot 0, so the first block is loaded as soon as started rises.
        cnt_d = started_q ? ((cnt_q == CNT_MAX) ? 7'd0 : cnt_q + 7'd1) : 7'd0;
        pause = (DATA_W == 32) ? (cnt_d >= 7'd64) : (cnt_d == 7'd32);
        load  = started_d && !pause && ((DATA_W == 64) || !cnt_d[0]);
        upper = started_d && !pause && (DATA_W == 32) && cnt_d[0];
        empty = (level_q == '0);
        push  = i_valid && o_ready;
        pop   = load && !empty;
        blk_d = load ? (empty ? {IDLE_HDR, IDLE_DATA} : mem_q[rd_q]) : blk_q;
        seq_d = (DATA_W == 32) ? {1'b0, cnt_d[6:1]} : cnt_d;
        hdr_d = load ? {1'b0, blk_d[65:64]} : hdr_q;
        data_d = load ? DATA_W'(blk_d[63:0]) : upper ? DATA_W'(blk_q[63:32]) : data_q;
        uf_d    = load && empty;
        level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
        wr_d    = wr_q + AW'(push);
        rd_d    = rd_q + AW'(pop);
        mem_d   = mem_q;
        if (push) mem_d[wr_q] = {i_header, i_data};
    end

    always_ff @(posedge i_usrclk2 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            started_q <= 1'b0;
            cnt_q     <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            level_q   <= '0;
            blk_q     <= '0;
            seq_q     <= '0;
            hdr_q     <= '0;
            data_q    <= '0;
            uf_q      <= 1'b0;
        end else begin
            started_q <= started_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            level_q   <= level_d;
            blk_q     <= blk_d;
            seq_q     <= seq_d;
            hdr_q     <= hdr_d;
            data_q    <= data_d;
            uf_q      <= uf_d;
        end
    end

    // Storage needs no reset: the pointers and level define which entries are live.
    always_ff @(posedge i_usrclk2) mem_q <= mem_d;
endmodule

// File: tb/tb_external_tx_gearbox_fifo.sv
// tb_external_tx_gearbox_fifo: directed self-checking bench for 32- and 64-bit gearbox feeders
module tb_external_tx_gearbox_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s32, v32, r32, uf32, s64, v64, r64, uf64;
    logic [1:0] h32, h64;
    logic [63:0] d32, d64, dt64;
    logic [6:0] q32, q64;
    logic [2:0] hd32, hd64, lv32, lv64;
    logic [31:0] dt32;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic st; logic v; logic [1:0] h; logic [63:0] d;
        logic [6:0] seq; logic [2:0] hdr; logic [31:0] dat; logic uf; logic rdy; logic [2:0] lvl;
    } vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;

    external_tx_gearbox_fifo #(.DATA_W(32)) u32 (
        .i_usrclk2(clk), .i_rst_n(rst_n), .i_startseq(s32), .i_valid(v32), .o_ready(r32),
        .i_header(h32), .i_data(d32), .o_txsequence(q32), .o_header(hd32), .o_data(dt32),
        .o_underflow(uf32), .o_fifo_level(lv32));

    external_tx_gearbox_fifo #(.DATA_W(64)) u64 (
        .i_usrclk2(clk), .i_rst_n(rst_n), .i_startseq(s64), .i_valid(v64), .o_ready(r64),
        .i_header(h64), .i_data(d64), .o_txsequence(q64), .o_header(hd64), .o_data(dt64),
        .o_underflow(uf64), .o_fifo_level(lv64));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [65:0] blk(input int i);
        return {(i % 2 == 1) ? 2'b01 : 2'b10, 32'(i) * 32'h9E37_79B9, 32'hC0DE_0000 + 32'(i)};
    endfunction

    initial begin
        logic [65:0] q[$];
        logic [65:0] b;
        logic [63:0] last_d;
        logic [2:0] last_h;
        int n, nout, npush, nuf, exp_seq;
        bit saw_full;
        tbl[0] = '{1'b1, 1'b1, 2'b00, 64'hDEAD_BEEF_DEAD_BEEF, 7'd0, 3'b010, 32'h1E, 1'b1, 1'b1, 3'd0};
        tbl[1] = '{1'b0, 1'b1, 2'b01, 64'hAAAA_BBBB_CCCC_DDDD, 7'd0, 3'b010, 32'h0, 1'b0, 1'b1, 3'd1};
        tbl[2] = '{1'b0, 1'b1, 2'b10, 64'h1111_2222_3333_4444, 7'd1, 3'b001, 32'hCCCC_DDDD, 1'b0, 1'b1, 3'd1};
        tbl[3] = '{1'b0, 1'b0, 2'b00, 64'h0, 7'd1, 3'b001, 32'hAAAA_BBBB, 1'b0, 1'b1, 3'd1};
        tbl[4] = '{1'b0, 1'b0, 2'b00, 64'h0, 7'd2, 3'b010, 32'h3333_4444, 1'b0, 1'b1, 3'd0};
        tbl[5] = '{1'b0, 1'b0, 2'b00, 64'h0, 7'd2, 3'b010, 32'h1111_2222, 1'b0, 1'b1, 3'd0};
        tbl[6] = '{1'b0, 1'b0, 2'b00, 64'h0, 7'd3, 3'b010, 32'h1E, 1'b1, 1'b1, 3'd0};
        tbl[7] = '{1'b0, 1'b0, 2'b00, 64'h0, 7'd3, 3'b010, 32'h0, 1'b0, 1'b1, 3'd0};
        s32 = 0; v32 = 0; h32 = 0; d32 = 0; s64 = 0; v64 = 0; h64 = 0; d64 = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // No start: outputs stay zero and pushes are refused.
        v32 = 1; h32 = 2'b01; d32 = 64'h1234; v64 = 1; h64 = 2'b01; d64 = 64'h5678;
        for (int i = 0; i < 100; i++) begin
            step;
            chk("idle32", {q32, hd32, dt32, uf32, r32, lv32}, '0);
            chk("idle64", {q64, hd64, dt64, uf64, r64, lv64}, '0);
        end
        v32 = 0; v64 = 0;

        for (int i = 0; i < 8; i++) begin
            s32 = tbl[i].st; v32 = tbl[i].v; h32 = tbl[i].h; d32 = tbl[i].d;
            step;
            chk($sformatf("vec%0d", i), {q32, hd32, dt32, uf32, r32, lv32},
                {tbl[i].seq, tbl[i].hdr, tbl[i].dat, tbl[i].uf, tbl[i].rdy, tbl[i].lvl});
        end
        s32 = 0; v32 = 0;

        // Starved FIFO: one idle block per block slot, 32 per 66-cycle period.
        n = 0;
        for (int i = 0; i < 66; i++) begin
            step;
            n += int'(uf32);
        end
        chk("uf_per_period32", n, 32);

        for (int i = 0; i < 100 && q32 != 7'd32; i++) step;
        chk("pause32_a", {q32, hd32, dt32, uf32}, {7'd32, 3'b010, 32'h0, 1'b0});
        step;
        chk("pause32_b", {q32, hd32, dt32, uf32}, {7'd32, 3'b010, 32'h0, 1'b0});
        step;
        chk("post_pause32", {q32, hd32, dt32, uf32}, {7'd0, 3'b010, 32'h1E, 1'b1});

        // Reset in the middle of a block, then restart cleanly.
        v32 = 1; h32 = 2'b11; d32 = 64'h0123_4567_89AB_CDEF;
        step;
        v32 = 0;
        for (int i = 0; i < 10 && hd32 != 3'b011; i++) step;
        chk("first_half32", {hd32, dt32}, {3'b011, 32'h89AB_CDEF});
        #2 rst_n = 1'b0;
        #1;
        chk("rst32", {q32, hd32, dt32, uf32, r32, lv32}, '0);
        chk("rst64", {q64, hd64, dt64, uf64, r64, lv64}, '0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        s32 = 1;
        step;
        s32 = 0;
        chk("restart32", {q32, hd32, dt32, uf32, r32, lv32}, {7'd0, 3'b010, 32'h1E, 1'b1, 1'b1, 3'd0});
        step;
        chk("restart_hi32", {q32, hd32, dt32, uf32}, {7'd0, 3'b010, 32'h0, 1'b0});

        // 64-bit stream of 100 blocks with scoreboard.
        nout = 0; npush = 0; nuf = 0; saw_full = 0; last_d = '0; last_h = '0;
        s64 = 1;
        step;
        s64 = 0;
        exp_seq = 0;
        for (int c = 0; c < 300 && nout < 100; c++) begin
            if (lv64 == 3'd4 && !r64) saw_full = 1;
            if (exp_seq == 32) begin
                chk("hold64", {q64, hd64, dt64, uf64}, {7'd32, last_h, last_d, 1'b0});
            end else if (uf64) begin
                nuf++;
                last_h = 3'b010; last_d = 64'h1E;
                chk("idle_blk64", {q64, hd64, dt64}, {7'(exp_seq), last_h, last_d});
            end else begin
                b = (q.size() > 0) ? q.pop_front() : '1;
                last_h = {1'b0, b[65:64]}; last_d = b[63:0];
                chk($sformatf("blk64_%0d", nout), {q64, hd64, dt64}, {7'(exp_seq), last_h, last_d});
                nout++;
            end
            v64 = (npush < 100);
            b = blk(npush);
            h64 = b[65:64]; d64 = b[63:0];
            if (v64 && r64) begin
                q.push_back(b);
                npush++;
            end
            step;
            exp_seq = (exp_seq == 32) ? 0 : exp_seq + 1;
        end
        v64 = 0;
        chk("blocks64", nout, 100);
        chk("uf_count64", nuf, 2);
        chk("full_seen64", 128'(saw_full), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
